exec_stage_pipe: RTL and testbench

Registered, parametrised execute stage sitting between register-read and memory-access in the Genie pipeline. It accepts one decoded instruction per cycle over a valid/ready handshake and computes ALU, shift, address, branch and jump results. Results and condition flags are registered. An iterative shift-add multiplier handles MUL, which back-pressures upstream while busy. Flush kills the in-flight instruction on a taken branch from a later stage.

---
 rtl/exec_stage_pipe_pkg.sv | 55 +++++
 rtl/exec_stage_pipe_iter_mul.sv | 53 +++++
 rtl/exec_stage_pipe.sv | 274 +++++++++++++++++++++++++++
 tb/tb_exec_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_stage_pipe_pkg.sv
// Shared opcode map, flag indices and multiplier FSM states
// for the Genie execute stage.
package exec_stage_pipe_pkg;

    localparam int WIDTH_DEF = 32;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h06;
    localparam logic [5:0] OP_ANDI = 6'h07;
    localparam logic [5:0] OP_ORI  = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h09;
    localparam logic [5:0] OP_SLL  = 6'h0A;
    localparam logic [5:0] OP_SRL  = 6'h0B;
    localparam logic [5:0] OP_SRA  = 6'h0C;
    localparam logic [5:0] OP_SLLV = 6'h0D;
    localparam logic [5:0] OP_SRLV = 6'h0E;
    localparam logic [5:0] OP_SRAV = 6'h0F;
    localparam logic [5:0] OP_LUI  = 6'h10;
    localparam logic [5:0] OP_LDI  = 6'h11;
    localparam logic [5:0] OP_LW   = 6'h12;
    localparam logic [5:0] OP_LH   = 6'h13;
    localparam logic [5:0] OP_LD   = 6'h14;
    localparam logic [5:0] OP_SW   = 6'h15;
    localparam logic [5:0] OP_SH   = 6'h16;
    localparam logic [5:0] OP_SD   = 6'h17;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_BNE  = 6'h19;
    localparam logic [5:0] OP_BGTZ = 6'h1A;
    localparam logic [5:0] OP_BLTZ = 6'h1B;
    localparam logic [5:0] OP_BLEZ = 6'h1C;
    localparam logic [5:0] OP_BGEZ = 6'h1D;
    localparam logic [5:0] OP_J    = 6'h1E;
    localparam logic [5:0] OP_JAL  = 6'h1F;
    localparam logic [5:0] OP_JR   = 6'h20;
    localparam logic [5:0] OP_JALR = 6'h21;
    localparam logic [5:0] OP_MUL  = 6'h22;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/exec_stage_pipe_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start, product held until the next start.
module iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q & (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/exec_stage_pipe.sv
// Genie execute stage: registered ALU/shift/address/branch results
// with an optional iterative multiplier that stalls upstream.
module exec_stage_pipe
    import exec_stage_pipe_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PC_W   = WIDTH - 2,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [WIDTH-1:0] data_c,
    output logic [WIDTH-1:0] addr,
    output logic             branch_taken,
    output logic [PC_W-1:0]  branch_addr,
    output logic             illegal,
    output logic [3:0]       flags
);

    localparam int SH_W = $clog2(WIDTH);

    mul_state_e state_q, state_d;

    logic             out_valid_q, taken_q, ill_q;
    logic [WIDTH-1:0] instr_q, data_c_q, addr_q;
    logic [PC_W-1:0]  pc_q, tgt_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] mul_instr_q;
    logic [PC_W-1:0]  mul_pc_q;

    logic [5:0]       op;
    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_s, imm_z, opb, st_addr;
    logic [WIDTH:0]   add_sum, sub_sum, sll_w, srl_w, sra_w;
    logic             add_v, sub_v, sh_var, a_neg, a_zero;
    logic [SH_W-1:0]  sh_amt;
    logic [PC_W-1:0]  br_tgt;

    logic [WIDTH-1:0] res_c, res_addr;
    logic [PC_W-1:0]  res_tgt;
    logic             res_taken, res_ill, upd_zn;
    logic [3:0]       res_f, mul_f;

    logic               accept, is_mul, mul_start, load_alu, load_mul;
    logic               mul_busy, mul_done, mul_hi;
    logic [2*WIDTH-1:0] mul_prod;

    assign op    = instr_in[WIDTH-1 -: 6];
    assign imm   = instr_in[15:0];
    assign imm_s = WIDTH'($signed(imm));
    assign imm_z = WIDTH'(imm);

    always_comb begin
        opb = data_b;
        if (op == OP_ADDI) opb = imm_s;
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) opb = imm_z;
    end

    assign add_sum = {1'b0, data_a} + {1'b0, opb};
    assign sub_sum = {1'b0, data_a} + {1'b0, ~data_b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v   = (data_a[WIDTH-1] == opb[WIDTH-1])
                   & (add_sum[WIDTH-1] != data_a[WIDTH-1]);
    assign sub_v   = (data_a[WIDTH-1] != data_b[WIDTH-1])
                   & (sub_sum[WIDTH-1] != data_a[WIDTH-1]);
    assign st_addr = data_b + imm_s;

    // extra guard bit on each shift catches the last bit shifted out
    assign sh_var = (op == OP_SLLV) | (op == OP_SRLV) | (op == OP_SRAV);
    assign sh_amt = sh_var ? data_b[SH_W-1:0] : SH_W'(instr_in[10:6]);
    assign sll_w  = {1'b0, data_a} << sh_amt;
    assign srl_w  = {data_a, 1'b0} >> sh_amt;
    assign sra_w  = $signed({data_a, 1'b0}) >>> sh_amt;

    assign a_neg  = data_a[WIDTH-1];
    assign a_zero = (data_a == '0);
    assign br_tgt = pc_in + data_b[PC_W-1:0];

    always_comb begin
        res_c     = '0;
        res_addr  = '0;
        res_tgt   = '0;
        res_taken = 1'b0;
        res_ill   = 1'b0;
        res_f     = flags_q;
        upd_zn    = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDI: begin
                res_c         = add_sum[WIDTH-1:0];
                res_f[FLAG_C] = add_sum[WIDTH];
                res_f[FLAG_V] = add_v;
                upd_zn        = 1'b1;
            end
            OP_SUB: begin
                res_c         = sub_sum[WIDTH-1:0];
                res_f[FLAG_C] = sub_sum[WIDTH];
                res_f[FLAG_V] = sub_v;
                upd_zn        = 1'b1;
            end
            OP_AND, OP_ANDI: begin res_c = data_a & opb; upd_zn = 1'b1; end
            OP_OR,  OP_ORI:  begin res_c = data_a | opb; upd_zn = 1'b1; end
            OP_XOR, OP_XORI: begin res_c = data_a ^ opb; upd_zn = 1'b1; end
            OP_SLL, OP_SLLV: begin
                res_c         = sll_w[WIDTH-1:0];
                res_f[FLAG_C] = sll_w[WIDTH];
                upd_zn        = 1'b1;
            end
            OP_SRL, OP_SRLV: begin
                res_c         = srl_w[WIDTH:1];
                res_f[FLAG_C] = srl_w[0];
                upd_zn        = 1'b1;
            end
            OP_SRA, OP_SRAV: begin
                res_c         = sra_w[WIDTH:1];
                res_f[FLAG_C] = sra_w[0];
                upd_zn        = 1'b1;
            end
            OP_LUI: res_c = WIDTH'({imm, 16'h0000});
            OP_LDI: res_c = imm_z;
            OP_LW, OP_LH, OP_LD: res_addr = add_sum[WIDTH-1:0];
            OP_SW, OP_SH, OP_SD: begin
                res_addr = st_addr;
                res_c    = data_a;
            end
            OP_BEQ:  begin res_tgt = br_tgt; res_taken = a_zero; end
            OP_BNE:  begin res_tgt = br_tgt; res_taken = !a_zero; end
            OP_BGTZ: begin res_tgt = br_tgt; res_taken = !a_neg & !a_zero; end
            OP_BLTZ: begin res_tgt = br_tgt; res_taken = a_neg; end
            OP_BLEZ: begin res_tgt = br_tgt; res_taken = a_neg | a_zero; end
            OP_BGEZ: begin res_tgt = br_tgt; res_taken = !a_neg; end
            OP_J:    begin res_tgt = data_a[PC_W-1:0]; res_taken = 1'b1; end
            OP_JAL: begin
                res_tgt   = data_a[PC_W-1:0];
                res_taken = 1'b1;
                res_c     = data_a;
            end
            OP_JR:   begin res_tgt = br_tgt; res_taken = 1'b1; end
            OP_JALR: begin
                res_c     = add_sum[WIDTH-1:0];
                res_tgt   = add_sum[PC_W-1:0];
                res_taken = 1'b1;
            end
            OP_NOP, OP_HALT: ;
            OP_MUL:  res_ill = !MUL_EN;
            default: res_ill = 1'b1;
        endcase
        if (upd_zn) begin
            res_f[FLAG_Z] = (res_c == '0);
            res_f[FLAG_N] = res_c[WIDTH-1];
        end
    end

    assign is_mul    = MUL_EN & (op == OP_MUL);
    assign in_ready  = (state_q == ST_IDLE) & (!out_valid_q | out_ready) & !flush;
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & is_mul;
    assign load_alu  = accept & !is_mul;
    assign load_mul  = (state_q == ST_DONE) & (!out_valid_q | out_ready) & !flush;

    assign mul_hi = |mul_prod[2*WIDTH-1:WIDTH];
    always_comb begin
        mul_f         = flags_q;
        mul_f[FLAG_C] = mul_hi;
        mul_f[FLAG_V] = mul_hi;
        mul_f[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_f[FLAG_N] = mul_prod[WIDTH-1];
    end

    generate
        if (MUL_EN) begin : g_mul
            iter_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (data_a),
                .b       (data_b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_prod)
            );
        end else begin : g_nomul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL: begin
                if (mul_done)       state_d = ST_DONE;
                else if (!mul_busy) state_d = ST_IDLE;
            end
            ST_DONE: if (load_mul) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mul_instr_q <= '0;
            mul_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mul_instr_q <= instr_in;
                mul_pc_q    <= pc_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            data_c_q    <= '0;
            addr_q      <= '0;
            taken_q     <= 1'b0;
            tgt_q       <= '0;
            ill_q       <= 1'b0;
            flags_q     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            instr_q     <= instr_in;
            pc_q        <= pc_in;
            data_c_q    <= res_c;
            addr_q      <= res_addr;
            taken_q     <= res_taken;
            tgt_q       <= res_tgt;
            ill_q       <= res_ill;
            flags_q     <= res_f;
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            instr_q     <= mul_instr_q;
            pc_q        <= mul_pc_q;
            data_c_q    <= mul_prod[WIDTH-1:0];
            addr_q      <= '0;
            taken_q     <= 1'b0;
            tgt_q       <= '0;
            ill_q       <= 1'b0;
            flags_q     <= mul_f;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign data_c       = data_c_q;
    assign addr         = addr_q;
    assign branch_taken = taken_q;
    assign branch_addr  = tgt_q;
    assign illegal      = ill_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Scoreboard bench for exec_stage_pipe: expectations queued at accept,
// compared when the output register is consumed.
module tb_exec_stage_pipe;
    import exec_stage_pipe_pkg::*;

    localparam int W  = 32;
    localparam int PW = 30;

    logic          clk, rst_n, in_valid, in_ready, flush;
    logic          out_valid, out_ready, branch_taken, illegal;
    logic [W-1:0]  instr_in, data_a, data_b, instr_out, data_c, addr;
    logic [PW-1:0] pc_in, pc_out, branch_addr;
    logic [3:0]    flags;

    exec_stage_pipe #(.WIDTH(W), .PC_W(PW), .MUL_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .data_a       (data_a),
        .data_b       (data_b),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .data_c       (data_c),
        .addr         (addr),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .illegal      (illegal),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  c;
        logic [3:0]    f;
        logic          t;
        logic [PW-1:0] tgt;
        logic          ill;
        logic [W-1:0]  a;
        logic [PW-1:0] pc;
        bit            ckc;
        bit            ckt;
        bit            cka;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   w, w2, nv;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ex(
        input logic [W-1:0] c, input logic [3:0] f, input logic t,
        input logic [PW-1:0] tgt, input logic ill, input logic [W-1:0] a,
        input logic [PW-1:0] pc, input bit ckc, input bit ckt, input bit cka);
        exp_t e;
        e.c = c; e.f = f; e.t = t; e.tgt = tgt; e.ill = ill;
        e.a = a; e.pc = pc; e.ckc = ckc; e.ckt = ckt; e.cka = cka;
        return e;
    endfunction

    function automatic logic [W-1:0] ins(input logic [5:0] op,
                                         input logic [15:0] imm);
        return {op, 10'h000, imm};
    endfunction

    task automatic send(input logic [W-1:0] i, input logic [PW-1:0] pc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit push, output int waited);
        instr_in = i;
        pc_in    = pc;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 200) begin
                chk("send_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                if (e.ckc) chk("data_c", data_c, e.c);
                chk("flags", flags, e.f);
                chk("taken", branch_taken, e.t);
                if (e.ckt) chk("branch_addr", branch_addr, e.tgt);
                chk("illegal", illegal, e.ill);
                if (e.cka) chk("addr", addr, e.a);
                chk("pc_out", pc_out, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr_in = '0; pc_in = '0; data_a = '0; data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_data_c", data_c, 0);
        chk("rst_addr", addr, 0);
        chk("rst_branch_addr", branch_addr, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        send(ins(OP_ADD, 0), 30'h10, 32'h7FFF_FFFF, 32'h1,
             ex(32'h8000_0000, 4'b0101, 0, 0, 0, 0, 30'h10, 1, 0, 0), 1, w);
        chk("add_latency", out_valid, 1);
        chk("add_instr_out", instr_out, ins(OP_ADD, 0));

        send(ins(OP_SUB, 0), 30'h14, 32'h5, 32'h5,
             ex(32'h0, 4'b1010, 0, 0, 0, 0, 30'h14, 1, 0, 0), 1, w);
        send(ins(OP_SRAV, 0), 30'h18, 32'h8000_0000, 32'h24,
             ex(32'hF800_0000, 4'b0001, 0, 0, 0, 0, 30'h18, 1, 0, 0), 1, w);
        chk("b2b_wait", w, 0);

        send(ins(OP_BNE, 0), 30'h100, 32'h1, 32'hFFFF_FFFC,
             ex(0, 4'b0001, 1, 30'h0FC, 0, 0, 30'h100, 0, 1, 0), 1, w);
        send(ins(OP_BNE, 0), 30'h100, 32'h0, 32'hFFFF_FFFC,
             ex(0, 4'b0001, 0, 0, 0, 0, 30'h100, 0, 0, 0), 1, w);

        send(ins(OP_ADD, 0), 30'h20, 32'hFFFF_FFFF, 32'h1,
             ex(32'h0, 4'b1010, 0, 0, 0, 0, 30'h20, 1, 0, 0), 1, w);
        send(ins(OP_XOR, 0), 30'h24, 32'h8000_0000, 32'h1,
             ex(32'h8000_0001, 4'b1001, 0, 0, 0, 0, 30'h24, 1, 0, 0), 1, w);
        send(ins(OP_SLL, 16'h0100), 30'h28, 32'hF000_0001, 32'h0,
             ex(32'h10, 4'b1000, 0, 0, 0, 0, 30'h28, 1, 0, 0), 1, w);
        send(ins(OP_SRL, 16'h0000), 30'h2C, 32'h3, 32'h0,
             ex(32'h3, 4'b0000, 0, 0, 0, 0, 30'h2C, 1, 0, 0), 1, w);
        send(ins(OP_SRA, 16'h07C0), 30'h30, 32'h8000_0000, 32'h0,
             ex(32'hFFFF_FFFF, 4'b0001, 0, 0, 0, 0, 30'h30, 1, 0, 0), 1, w);
        send(ins(OP_LUI, 16'h1234), 30'h34, 32'h0, 32'h0,
             ex(32'h1234_0000, 4'b0001, 0, 0, 0, 0, 30'h34, 1, 0, 0), 1, w);
        send(ins(OP_LDI, 16'hBEEF), 30'h38, 32'h0, 32'h0,
             ex(32'h0000_BEEF, 4'b0001, 0, 0, 0, 0, 30'h38, 1, 0, 0), 1, w);
        send(ins(OP_LW, 0), 30'h3C, 32'h1000, 32'h20,
             ex(0, 4'b0001, 0, 0, 0, 32'h1020, 30'h3C, 0, 0, 1), 1, w);
        send(ins(OP_SW, 16'hFFF0), 30'h40, 32'hDEAD, 32'h100,
             ex(32'hDEAD, 4'b0001, 0, 0, 0, 32'hF0, 30'h40, 1, 0, 1), 1, w);
        send(ins(OP_JALR, 0), 30'h44, 32'h200, 32'h40,
             ex(32'h240, 4'b0001, 1, 30'h240, 0, 0, 30'h44, 1, 1, 0), 1, w);
        send(ins(6'h3E, 0), 30'h48, 32'h7, 32'h9,
             ex(32'h0, 4'b0001, 0, 0, 1, 0, 30'h48, 1, 0, 0), 1, w);

        send(ins(OP_MUL, 0), 30'h300, 32'h1_0000, 32'h1_0000,
             ex(32'h0, 4'b1110, 0, 0, 0, 0, 30'h300, 1, 0, 0), 1, w);
        send(ins(OP_ADD, 0), 30'h304, 32'h2, 32'h3,
             ex(32'h5, 4'b0000, 0, 0, 0, 0, 30'h304, 1, 0, 0), 1, w);
        chk("mul_stall_cycles", w, W + 2);

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(ins(OP_ADD, 0), 30'h400, 32'hFFFF_FFFF, 32'h3,
             ex(32'h2, 4'b1000, 0, 0, 0, 0, 30'h400, 1, 0, 0), 1, w);
        fork
            send(ins(OP_SUB, 0), 30'h404, 32'h4, 32'h9,
                 ex(32'hFFFF_FFFB, 4'b0001, 0, 0, 0, 0, 30'h404, 1, 0, 0), 1, w2);
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data_c", data_c, 32'h2);
            chk("stall_flags", flags, 4'b1000);
            chk("stall_pc", pc_out, 30'h400);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait fork;
        chk("stall_wait", w2, 3);

        repeat (2) @(posedge clk);
        #1;
        send(ins(OP_MUL, 0), 30'h500, 32'h3, 32'h7,
             ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, w);
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_flags", flags, 4'b0001);
        nv = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("flush_no_output", nv, 0);

        @(posedge clk);
        #1;
        send(ins(OP_MUL, 0), 30'h600, 32'h5, 32'h5,
             ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, w);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmul_out_valid", out_valid, 0);
        chk("rstmul_flags", flags, 0);
        chk("rstmul_data_c", data_c, 0);
        chk("rstmul_pc_out", pc_out, 0);
        chk("rstmul_instr_out", instr_out, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        nv = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("rstmul_no_output", nv, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
